// File: rtl/dma_wb_bridge_if.sv
// Bundles the accelerator DMA handshake and the Wishbone master bus of dma_wb_bridge.
// The master modport is the bridge's view. The slave modport is the environment's view:
// it drives the accelerator request and the Wishbone responses.
interface dma_wb_bridge_if;
    // Accelerator DMA side
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_data_o;
    logic [31:0] dma_data_i;
    logic        dma_ack;

    // Wishbone master side
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  dma_req,
        input  dma_we,
        input  dma_addr,
        input  dma_data_o,
        output dma_data_i,
        output dma_ack,
        output wbm_adr_o,
        output wbm_dat_o,
        input  wbm_dat_i,
        output wbm_we_o,
        output wbm_sel_o,
        output wbm_cyc_o,
        output wbm_stb_o,
        input  wbm_ack_i,
        input  wbm_err_i
    );

    modport slave (
        output dma_req,
        output dma_we,
        output dma_addr,
        output dma_data_o,
        input  dma_data_i,
        input  dma_ack,
        input  wbm_adr_o,
        input  wbm_dat_o,
        output wbm_dat_i,
        input  wbm_we_o,
        input  wbm_sel_o,
        input  wbm_cyc_o,
        input  wbm_stb_o,
        output wbm_ack_i,
        output wbm_err_i
    );
endinterface

// File: rtl/dma_wb_bridge.sv
// dma_wb_bridge: services the matrix accelerator's DMA word handshake as a Wishbone master.
// Each request becomes one single-word WB cycle: A/B loads become reads, C stores become writes.
// Bus errors, misaligned addresses and abandoned requests are absorbed. Every accepted request
// is acked, so the accelerator never hangs, and failures raise the sticky err_flag.
// Optional feature: define DMA_TIMEOUT_EN to bound the WB wait to TIMEOUT_CYCLES cycles.
// Without the macro, BUS waits indefinitely for ack/err.
module dma_wb_bridge #(
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dma_wb_bridge_if.master        bus,
    input  logic                   err_clr,
    output logic                   busy,
    output logic                   err_flag,
    output logic [15:0]            xfer_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdat_q, rdat_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;
    logic [15:0] cnt_q, cnt_d;

    logic        in_bus;
    logic        timeout;
    logic        aborting;
    logic        err_set;

    assign in_bus = (state_q == ST_BUS);

`ifdef DMA_TIMEOUT_EN
    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_q, wait_d;

    // Wait counter: held at zero outside BUS, so it restarts on every BUS entry
    always_comb begin
        wait_d = 8'd0;
        if (in_bus) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // Expires during the last permitted strobe cycle, so stb is high TIMEOUT_CYCLES cycles
    assign timeout = in_bus && (wait_q == WaitLast);

    // Wait counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    // Abandoned request: WB cycle still finishes, but the accelerator is not acked
    assign aborting = abort_q | ~bus.dma_req;

    // Next-state logic for the transfer FSM, request latches, read data and status
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        we_d    = we_q;
        abort_d = abort_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.dma_req) begin
                    we_d = bus.dma_we;
                    if (bus.dma_addr[1:0] == 2'b00) begin
                        adr_d   = bus.dma_addr;
                        wdat_d  = bus.dma_data_o;
                        abort_d = 1'b0;
                        state_d = ST_BUS;
                    end else begin
                        // Misaligned: skip the bus entirely and ack with an error
                        err_set = 1'b1;
                        if (!bus.dma_we) begin
                            rdat_d = ERR_DATA;
                        end
                        state_d = ST_RESP;
                    end
                end
            end

            ST_BUS: begin
                abort_d = aborting;
                // err wins over a simultaneous ack; timeout only when the slave is silent
                if (bus.wbm_err_i || (!bus.wbm_ack_i && timeout)) begin
                    err_set = 1'b1;
                    if (!we_q && !aborting) begin
                        rdat_d = ERR_DATA;
                    end
                    state_d = aborting ? ST_IDLE : ST_RESP;
                end else if (bus.wbm_ack_i) begin
                    if (!we_q && !aborting) begin
                        rdat_d = bus.wbm_dat_i;
                    end
                    state_d = aborting ? ST_IDLE : ST_RESP;
                end
            end

            ST_RESP: begin
                cnt_d   = cnt_q + 16'd1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error outranks a clear in the same cycle
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State, latches and status registers; async reset aborts any bus cycle at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            adr_q   <= 32'd0;
            wdat_q  <= 32'd0;
            rdat_q  <= 32'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            we_q    <= we_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus and accelerator outputs decoded straight from state, so a reset drops them immediately
    assign bus.wbm_cyc_o  = in_bus;
    assign bus.wbm_stb_o  = in_bus;
    assign bus.wbm_sel_o  = in_bus ? 4'hF : 4'h0;
    assign bus.wbm_adr_o  = adr_q;
    assign bus.wbm_dat_o  = wdat_q;
    assign bus.wbm_we_o   = we_q;
    assign bus.dma_data_i = rdat_q;
    assign bus.dma_ack    = (state_q == ST_RESP);

    assign busy       = (state_q != ST_IDLE);
    assign err_flag   = err_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_dma_wb_bridge.sv
// Self-checking bench for dma_wb_bridge. A behavioural Wishbone slave with configurable wait,
// error and silent modes answers the bridge. Expected accelerator read data is queued when a
// request is driven and popped when dma_ack arrives.
// Define DMA_TIMEOUT_EN to exercise the timeout build.
module tb_dma_wb_bridge;

    localparam logic [31:0] ErrData   = 32'hDEADBEEF;
    localparam int unsigned TmoCycles = 4;

    logic        clk;
    logic        reset_n;
    logic        err_clr;
    logic        busy;
    logic        err_flag;
    logic [15:0] xfer_count;

    dma_wb_bridge_if bus ();

    dma_wb_bridge #(
        .ERR_DATA       (ErrData),
        .TIMEOUT_CYCLES (TmoCycles)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.master),
        .err_clr    (err_clr),
        .busy       (busy),
        .err_flag   (err_flag),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard and reference model state
    logic [31:0] exp_q[$];
    logic [31:0] exp_rd;
    logic [15:0] exp_count;

    // Slave configuration and the last bus cycle the slave terminated
    int          slave_wait;
    bit          slave_err;
    bit          slave_silent;
    logic [31:0] slave_rdata;
    int          stb_cnt;
    logic [31:0] seen_adr;
    logic [31:0] seen_dat;
    logic        seen_we;
    logic [3:0]  seen_sel;

    // Wishbone slave: answers on the slave_wait-th strobe cycle (0 = same cycle)
    always @(negedge clk) begin
        if (!reset_n || !(bus.wbm_cyc_o && bus.wbm_stb_o)) begin
            stb_cnt       = 0;
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            bus.wbm_dat_i = 32'h0;
        end else begin
            if (!slave_silent && stb_cnt == slave_wait) begin
                bus.wbm_ack_i = !slave_err;
                bus.wbm_err_i = slave_err;
                bus.wbm_dat_i = bus.wbm_we_o ? 32'hBAD0_0BAD : slave_rdata;
                seen_adr      = bus.wbm_adr_o;
                seen_dat      = bus.wbm_dat_o;
                seen_we       = bus.wbm_we_o;
                seen_sel      = bus.wbm_sel_o;
            end else begin
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
            end
            stb_cnt++;
        end
    end

    // Accelerator driver: call at a negedge; cycle numbers count negedges after the request
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int budget, output int stb_cycles, output int ack_at,
                           output logic [31:0] rdata);
        bus.dma_req    = 1'b1;
        bus.dma_we     = we;
        bus.dma_addr   = addr;
        bus.dma_data_o = wdata;
        stb_cycles     = 0;
        ack_at         = -1;
        rdata          = 32'h0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.wbm_stb_o) stb_cycles++;
            if (bus.dma_ack) begin
                ack_at = i;
                rdata  = bus.dma_data_i;
                break;
            end
        end
        bus.dma_req = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        bus.dma_req    = 1'b0;
        bus.dma_we     = 1'b0;
        bus.dma_addr   = 32'h0;
        bus.dma_data_o = 32'h0;
        err_clr        = 1'b0;
        repeat (3) @(negedge clk);
        reset_n   = 1'b1;
        exp_count = 16'd0;
        exp_rd    = 32'h0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] ctl;
        slave_wait   = 0;
        slave_err    = 1'b0;
        slave_silent = 1'b0;
        slave_rdata  = 32'h0;
        reset_n      = 1'b0;
        bus.dma_req  = 1'b0;
        err_clr      = 1'b0;
        repeat (2) @(negedge clk);
        ctl = {bus.wbm_cyc_o, bus.wbm_stb_o, bus.dma_ack, bus.wbm_we_o, bus.wbm_sel_o,
               busy, err_flag};
        n_checks++;
        if (ctl !== 10'd0) begin
            n_fail++; $display("FAIL reset_ctl: got %b, want 0", ctl);
        end
        n_checks++;
        if (xfer_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_count: got %h, want 0", xfer_count);
        end
        n_checks++;
        if (bus.dma_data_i !== 32'd0) begin
            n_fail++; $display("FAIL reset_rdata: got %h, want 0", bus.dma_data_i);
        end
        n_checks++;
        if (bus.wbm_adr_o !== 32'd0 || bus.wbm_dat_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got adr %h dat %h, want 0", bus.wbm_adr_o, bus.wbm_dat_o);
        end
        apply_reset();
    endtask

    // Read 0x1000 with a one-wait-state slave returning 7
    task automatic test_read_wait(input string tag);
        int          stb;
        int          ack_at;
        logic [31:0] rd;
        logic [31:0] exp;
        slave_wait  = 1;
        slave_rdata = 32'h0000_0007;
        exp_rd      = 32'h0000_0007;
        exp_q.push_back(exp_rd);
        run_txn(1'b0, 32'h0000_1000, 32'h0, 20, stb, ack_at, rd);
        n_checks++;
        if (ack_at !== 3) begin
            n_fail++; $display("FAIL %s_ack_cycle: got %0d, want 3", tag, ack_at);
        end
        n_checks++;
        if (stb !== 2) begin
            n_fail++; $display("FAIL %s_stb_cycles: got %0d, want 2", tag, stb);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (rd !== exp) begin
            n_fail++; $display("FAIL %s_rdata: got %h, want %h", tag, rd, exp);
        end
        n_checks++;
        if (seen_adr !== 32'h1000 || seen_we !== 1'b0 || seen_sel !== 4'hF) begin
            n_fail++;
            $display("FAIL %s_bus: got adr %h we %b sel %h, want 1000 0 f", tag, seen_adr,
                     seen_we, seen_sel);
        end
        @(negedge clk);
        exp_count++;
        n_checks++;
        if (xfer_count !== exp_count || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_count: got %0d busy %b, want %0d busy 0", tag, xfer_count, busy,
                     exp_count);
        end
    endtask

    // Zero-wait write immediately followed by a read with dma_req held high
    task automatic test_back_to_back();
        int          ack1 = -1;
        int          ack2 = -1;
        int          stb2 = -1;
        logic [31:0] rd1 = 32'h0;
        logic [31:0] rd2 = 32'h0;
        logic [31:0] w_adr = 32'h0;
        logic [31:0] w_dat = 32'h0;
        logic        w_we = 1'b0;
        logic [3:0]  w_sel = 4'h0;
        logic [31:0] exp;
        slave_wait     = 0;
        slave_rdata    = 32'h0000_0055;
        exp_q.push_back(exp_rd);
        exp_q.push_back(32'h0000_0055);
        bus.dma_req    = 1'b1;
        bus.dma_we     = 1'b1;
        bus.dma_addr   = 32'h0000_2004;
        bus.dma_data_o = 32'h0000_002A;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.dma_ack && ack1 == -1) begin
                ack1  = i;
                rd1   = bus.dma_data_i;
                w_adr = seen_adr;
                w_dat = seen_dat;
                w_we  = seen_we;
                w_sel = seen_sel;
                bus.dma_we   = 1'b0;
                bus.dma_addr = 32'h0000_1008;
            end else if (bus.dma_ack) begin
                ack2 = i;
                rd2  = bus.dma_data_i;
                break;
            end
            if (bus.wbm_stb_o && ack1 != -1 && stb2 == -1) stb2 = i;
        end
        bus.dma_req = 1'b0;
        n_checks++;
        if (ack1 !== 2) begin
            n_fail++; $display("FAIL b2b_write_ack: got %0d, want 2", ack1);
        end
        n_checks++;
        if (w_adr !== 32'h2004 || w_dat !== 32'h2A || w_we !== 1'b1 || w_sel !== 4'hF) begin
            n_fail++;
            $display("FAIL b2b_write_bus: got adr %h dat %h we %b sel %h, want 2004 2a 1 f",
                     w_adr, w_dat, w_we, w_sel);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (rd1 !== exp) begin
            n_fail++; $display("FAIL b2b_write_holds_rdata: got %h, want %h", rd1, exp);
        end
        n_checks++;
        if (stb2 !== 4 || ack2 !== 5) begin
            n_fail++; $display("FAIL b2b_next_timing: got stb %0d ack %0d, want 4 5", stb2, ack2);
        end
        exp    = exp_q.pop_front();
        exp_rd = 32'h0000_0055;
        n_checks++;
        if (rd2 !== exp) begin
            n_fail++; $display("FAIL b2b_read_data: got %h, want %h", rd2, exp);
        end
        @(negedge clk);
        exp_count += 16'd2;
        n_checks++;
        if (xfer_count !== exp_count) begin
            n_fail++; $display("FAIL b2b_count: got %0d, want %0d", xfer_count, exp_count);
        end
    endtask

    task automatic test_bus_error();
        int          stb;
        int          ack_at;
        logic [31:0] rd;
        logic [31:0] exp;
        slave_wait = 0;
        slave_err  = 1'b1;
        exp_rd     = ErrData;
        exp_q.push_back(exp_rd);
        run_txn(1'b0, 32'h0000_3000, 32'h0, 20, stb, ack_at, rd);
        slave_err = 1'b0;
        exp       = exp_q.pop_front();
        n_checks++;
        if (ack_at !== 2 || rd !== exp) begin
            n_fail++;
            $display("FAIL buserr_ack: got cycle %0d data %h, want 2 %h", ack_at, rd, exp);
        end
        n_checks++;
        if (err_flag !== 1'b1) begin
            n_fail++; $display("FAIL buserr_flag_set: got %b, want 1", err_flag);
        end
        exp_count++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (err_flag !== 1'b1 || xfer_count !== exp_count) begin
            n_fail++;
            $display("FAIL buserr_sticky: got flag %b count %0d, want 1 %0d", err_flag,
                     xfer_count, exp_count);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (err_flag !== 1'b0) begin
            n_fail++; $display("FAIL buserr_clear: got %b, want 0", err_flag);
        end
    endtask

    task automatic test_misaligned();
        int          stb;
        int          ack_at;
        logic [31:0] rd;
        logic [31:0] exp;
        exp_rd = ErrData;
        exp_q.push_back(exp_rd);
        run_txn(1'b0, 32'h0000_1002, 32'h0, 20, stb, ack_at, rd);
        exp = exp_q.pop_front();
        n_checks++;
        if (stb !== 0 || ack_at !== 1) begin
            n_fail++; $display("FAIL misalign_timing: got stb %0d ack %0d, want 0 1", stb, ack_at);
        end
        n_checks++;
        if (rd !== exp || err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_result: got data %h flag %b, want %h 1", rd, err_flag, exp);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_count++;
        n_checks++;
        if (xfer_count !== exp_count || err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_after: got count %0d flag %b, want %0d 0", xfer_count,
                     err_flag, exp_count);
        end
    endtask

    // Accelerator drops dma_req mid-cycle: WB cycle finishes, no ack, no count
    task automatic test_req_drop();
        int acks = 0;
        slave_wait     = 3;
        slave_rdata    = 32'h0000_0099;
        bus.dma_req    = 1'b1;
        bus.dma_we     = 1'b0;
        bus.dma_addr   = 32'h0000_4000;
        bus.dma_data_o = 32'h0;
        @(negedge clk);
        bus.dma_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.dma_ack) acks++;
        end
        n_checks++;
        if (acks !== 0 || xfer_count !== exp_count) begin
            n_fail++;
            $display("FAIL reqdrop_ack: got acks %0d count %0d, want 0 %0d", acks, xfer_count,
                     exp_count);
        end
        n_checks++;
        if (busy !== 1'b0 || bus.dma_data_i !== exp_rd) begin
            n_fail++;
            $display("FAIL reqdrop_state: got busy %b data %h, want 0 %h", busy, bus.dma_data_i,
                     exp_rd);
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int stb  = 0;
        slave_silent   = 1'b1;
        bus.dma_req    = 1'b1;
        bus.dma_we     = 1'b0;
        bus.dma_addr   = 32'h0000_5000;
        repeat (2) begin
            @(negedge clk);
            if (bus.wbm_stb_o) stb++;
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (stb !== 2 || bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_drop: got stb_seen %0d cyc %b stb %b busy %b, want 2 0 0 0",
                     stb, bus.wbm_cyc_o, bus.wbm_stb_o, busy);
        end
        bus.dma_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.dma_ack) acks++;
        end
        n_checks++;
        if (acks !== 0 || xfer_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_noack: got acks %0d count %0d, want 0 0", acks, xfer_count);
        end
        slave_silent = 1'b0;
        reset_n      = 1'b1;
        exp_count    = 16'd0;
        exp_rd       = 32'h0;
        exp_q.delete();
        @(negedge clk);
        test_read_wait("rerun");
    endtask

    task automatic test_timeout();
        int          stb;
        int          ack_at;
        logic [31:0] rd;
        slave_silent = 1'b1;
`ifdef DMA_TIMEOUT_EN
        begin
            logic [31:0] exp;
            exp_rd = ErrData;
            exp_q.push_back(exp_rd);
            run_txn(1'b0, 32'h0000_6000, 32'h0, 20, stb, ack_at, rd);
            exp = exp_q.pop_front();
            n_checks++;
            if (stb !== 4 || ack_at !== 5) begin
                n_fail++;
                $display("FAIL timeout_timing: got stb %0d ack %0d, want 4 5", stb, ack_at);
            end
            n_checks++;
            if (rd !== exp || err_flag !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_result: got data %h flag %b, want %h 1", rd, err_flag, exp);
            end
        end
`else
        run_txn(1'b0, 32'h0000_6000, 32'h0, 20, stb, ack_at, rd);
        n_checks++;
        if (ack_at !== -1 || stb !== 20) begin
            n_fail++;
            $display("FAIL notimeout_wait: got ack %0d stb %0d, want -1 20", ack_at, stb);
        end
        n_checks++;
        if (bus.wbm_cyc_o !== 1'b1 || busy !== 1'b1 || err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL notimeout_state: got cyc %b busy %b flag %b, want 1 1 0",
                     bus.wbm_cyc_o, busy, err_flag);
        end
`endif
        slave_silent = 1'b0;
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_read_wait("read");
        test_back_to_back();
        test_bus_error();
        test_misaligned();
        test_req_drop();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound in case the run stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
